// File: rtl/multicycle_ctrl_fsm.sv
// Control unit for the multicycle ARM-subset processor: Moore main FSM, instruction
// field decode, NZCV flag register and per-instruction condition latch.
module multicycle_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       set_flags;
  logic       rd_is_pc;
  logic       unused_instr_bits;

  assign cond              = Instr[19:16];
  assign op                = Instr[15:14];
  assign funct             = Instr[13:8];
  assign rd                = Instr[3:0];
  assign cmd               = funct[4:1];
  assign set_flags         = funct[0];
  assign rd_is_pc          = (rd == 4'd15);
  assign unused_instr_bits = ^Instr[7:4];

  // Condition evaluation against the architectural flags
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Data-processing command decode
  logic [3:0] cmd_alu;
  logic       cmd_ok;
  logic       cmd_cmp;
  logic       cmd_arith;

  always_comb begin
    cmd_alu   = ALU_ADD;
    cmd_ok    = 1'b0;
    cmd_cmp   = 1'b0;
    cmd_arith = 1'b0;
    case (cmd)
      4'b0100: begin cmd_alu = ALU_ADD; cmd_ok = 1'b1; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = ALU_SUB; cmd_ok = 1'b1; cmd_arith = 1'b1; end
      4'b0000: begin cmd_alu = ALU_AND; cmd_ok = 1'b1; end
      4'b1100: begin cmd_alu = ALU_ORR; cmd_ok = 1'b1; end
      4'b1010: begin cmd_alu = ALU_SUB; cmd_cmp = 1'b1; cmd_arith = 1'b1; end
      default: begin cmd_alu = ALU_ADD; end
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Condition is frozen in DECODE so an EXECUTE flag update cannot alter this instruction
  always_comb begin
    condex_d = condex_q;
    flags_d  = flags_q;
    if (state_q == S_DECODE) begin
      condex_d = cond_pass;
    end
    if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && condex_q) begin
      if (cmd_cmp || (set_flags && cmd_ok)) begin
        flags_d[3:2] = ALUFlags[3:2];
        if (cmd_arith) begin
          flags_d[1:0] = ALUFlags[1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // While in reset the outputs decode FETCH and every write enable is held low
  state_e out_state;
  logic   pc_we, ir_we, mem_we, reg_we;

  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (out_state)
      S_FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        pc_we     = rd_is_pc && condex_q;
        reg_we    = !rd_is_pc && condex_q;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = condex_q;
      end
      S_EXECUTER: begin
        ALUControl = cmd_alu;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = cmd_alu;
      end
      S_ALUWB: begin
        if (cmd_ok) begin
          pc_we  = rd_is_pc && condex_q;
          reg_we = !rd_is_pc && condex_q;
        end
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_we     = condex_q;
      end
      default: begin
      end
    endcase
  end

  assign PCWrite  = pc_we && !reset;
  assign IRWrite  = ir_we && !reset;
  assign MemWrite = mem_we && !reset;
  assign RegWrite = reg_we && !reset;

  assign RegSrc = {(op == 2'b01), (op == 2'b10)};
  assign ImmSrc = op;
  assign State  = state_q;

endmodule
